// File: rtl/data_cache_controller.sv
// data_cache_controller: two-way set-associative, write-through, no-allocate read cache
// between the MEM stage and the SRAM controller.
//   clk, rst (async, active-low)
//   mem_r_en, mem_w_en, address, w_data -> r_data, ready   : MEM stage side
//   sram_r_en, sram_w_en, sram_address, sram_w_data,
//   sram_r_data, sram_ready                                 : SRAM controller side
module data_cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_w_data,
    input  logic [63:0] sram_r_data,
    input  logic        sram_ready
);
    localparam int IW = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    state_t            state, next;
    logic [SETS-1:0]   valid0, valid1, lru;
    logic [TAG_W-1:0]  tag0 [SETS];
    logic [TAG_W-1:0]  tag1 [SETS];
    logic [63:0]       data0 [SETS];
    logic [63:0]       data1 [SETS];
    logic [IW-1:0]     idx;
    logic [TAG_W-1:0]  tag;
    logic              hit0, hit1, hit, hway, victim, fill, upd, touch;
    logic [63:0]       hit_blk;

    assign idx     = address[IW+2:3];
    assign tag     = address[TAG_W+IW+2:IW+3];
    assign hit0    = valid0[idx] && tag0[idx] == tag;
    assign hit1    = valid1[idx] && tag1[idx] == tag;
    assign hit     = hit0 || hit1;
    assign hway    = hit1;
    assign hit_blk = hit1 ? data1[idx] : data0[idx];
    assign victim  = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
    // Storage updates are gated by rst so a reset mid-miss never fills.
    assign fill    = rst && state == READ_MISS && sram_ready;
    assign upd     = rst && state == IDLE && mem_w_en && hit;
    assign touch   = rst && state == IDLE && !mem_w_en && mem_r_en && hit;

    // With rst low every output holds its reset value regardless of inputs.
    always_comb begin
        next         = state;
        ready        = 1'b1;
        r_data       = '0;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        sram_address = '0;
        sram_w_data  = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        ready = 1'b0;
                        next  = WRITE;
                    end else if (mem_r_en) begin
                        if (hit) begin
                            r_data = address[2] ? hit_blk[63:32] : hit_blk[31:0];
                        end else begin
                            ready = 1'b0;
                            next  = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    sram_r_en    = 1'b1;
                    sram_address = {address[31:3], 3'b000};
                    ready        = sram_ready;
                    if (sram_ready) begin
                        r_data = address[2] ? sram_r_data[63:32] : sram_r_data[31:0];
                        next   = IDLE;
                    end
                end
                WRITE: begin
                    sram_w_en    = 1'b1;
                    sram_address = address;
                    sram_w_data  = w_data;
                    ready        = sram_ready;
                    if (sram_ready) next = IDLE;
                end
                default: next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            state <= next;
            if (fill) begin
                if (victim) valid1[idx] <= 1'b1;
                else        valid0[idx] <= 1'b1;
                lru[idx] <= ~victim;
            end else if (upd || touch) begin
                lru[idx] <= ~hway;
            end
        end
    end

    // Tags and blocks need no reset: they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                data1[idx] <= sram_r_data;
                tag1[idx]  <= tag;
            end else begin
                data0[idx] <= sram_r_data;
                tag0[idx]  <= tag;
            end
        end
        if (upd) begin
            if (hway) begin
                if (address[2]) data1[idx][63:32] <= w_data;
                else            data1[idx][31:0]  <= w_data;
            end else begin
                if (address[2]) data0[idx][63:32] <= w_data;
                else            data0[idx][31:0]  <= w_data;
            end
        end
    end
endmodule
